// File: rtl/circuito_sequencia_rodadas_pkg.sv
// Shared state codes and width helpers for the round-based sequence game.
package circuito_sequencia_rodadas_pkg;

  localparam logic [3:0] ST_INICIAL     = 4'h0;
  localparam logic [3:0] ST_PREPARA     = 4'h1;
  localparam logic [3:0] ST_ESPERA      = 4'h3;
  localparam logic [3:0] ST_REGISTRA    = 4'h4;
  localparam logic [3:0] ST_COMPARA     = 4'h5;
  localparam logic [3:0] ST_PROXIMO     = 4'h6;
  localparam logic [3:0] ST_PROX_RODADA = 4'h7;
  localparam logic [3:0] ST_FIM_ACERTO  = 4'hA;
  localparam logic [3:0] ST_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] ST_FIM_ERRO    = 4'hE;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // A zero TIMEOUT still needs a 1-bit timer so the datapath elaborates.
  function automatic int timer_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/circuito_sequencia_rodadas_fluxo_dados.sv
// Datapath: position/round counters, jogada timer, jogada register, edge detector, comparator.
module sequencia_fluxo_dados
  import circuito_sequencia_rodadas_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 5000,
  localparam int ADDR_W  = addr_w(DEPTH),
  localparam int TMR_W   = timer_w(TIMEOUT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zera,
  input  logic              conta_tempo,
  input  logic              zera_tempo,
  input  logic              registra,
  input  logic              inc_contagem,
  input  logic              inc_rodada,
  input  logic [WIDTH-1:0]  chaves,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              jogada,
  output logic              fim_tempo,
  output logic              igual,
  output logic              contagem_menor,
  output logic              ultima_rodada,
  output logic [ADDR_W-1:0] contagem,
  output logic [ADDR_W-1:0] rodada,
  output logic [WIDTH-1:0]  jogada_reg
);

  localparam logic [TMR_W-1:0]  T_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] chaves_ant;
  logic [TMR_W-1:0] timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chaves_ant <= '0;
    else       chaves_ant <= chaves;
  end

  // Saturating timer so a long stall can never alias back to an early count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          timer <= '0;
    else if (zera || zera_tempo)        timer <= '0;
    else if (conta_tempo && timer != '1) timer <= timer + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
      rodada   <= '0;
    end else if (zera) begin
      contagem <= '0;
      rodada   <= '0;
    end else if (inc_rodada) begin
      contagem <= '0;
      rodada   <= rodada + 1'b1;
    end else if (inc_contagem) begin
      contagem <= contagem + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         jogada_reg <= '0;
    else if (zera)     jogada_reg <= '0;
    else if (registra) jogada_reg <= chaves;
  end

  assign jogada         = (chaves != '0) && (chaves_ant == '0);
  assign fim_tempo      = (TIMEOUT > 0) && (timer == T_LAST);
  assign igual          = (jogada_reg == mem_data);
  assign contagem_menor = (contagem < rodada);
  assign ultima_rodada  = (rodada == R_LAST);

endmodule

// File: rtl/circuito_sequencia_rodadas.sv
// Round-based sequence game: FSM controller around the sequencia_fluxo_dados datapath.
module circuito_sequencia_rodadas
  import circuito_sequencia_rodadas_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 5000,
  localparam int ADDR_W  = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [WIDTH-1:0]  chaves,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [3:0]        db_estado,
  output logic [ADDR_W-1:0] db_rodada,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [WIDTH-1:0]  db_jogada,
  output logic              db_igual
);

  logic [3:0] estado, prox;
  logic zera, conta_tempo, zera_tempo, registra, inc_contagem, inc_rodada;
  logic jogada, fim_tempo, igual, contagem_menor, ultima_rodada;
  logic [ADDR_W-1:0] contagem, rodada;
  logic [WIDTH-1:0]  jogada_reg;

  sequencia_fluxo_dados #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_fd (
    .clock         (clock),
    .reset         (reset),
    .zera          (zera),
    .conta_tempo   (conta_tempo),
    .zera_tempo    (zera_tempo),
    .registra      (registra),
    .inc_contagem  (inc_contagem),
    .inc_rodada    (inc_rodada),
    .chaves        (chaves),
    .mem_data      (mem_data),
    .jogada        (jogada),
    .fim_tempo     (fim_tempo),
    .igual         (igual),
    .contagem_menor(contagem_menor),
    .ultima_rodada (ultima_rodada),
    .contagem      (contagem),
    .rodada        (rodada),
    .jogada_reg    (jogada_reg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= ST_INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      ST_INICIAL:     if (iniciar) prox = ST_PREPARA;
      ST_PREPARA:     prox = ST_ESPERA;
      // A jogada takes priority over a timeout landing in the same cycle.
      ST_ESPERA:      if (jogada)         prox = ST_REGISTRA;
                      else if (fim_tempo) prox = ST_FIM_TIMEOUT;
      ST_REGISTRA:    prox = ST_COMPARA;
      ST_COMPARA:     if (!igual)              prox = ST_FIM_ERRO;
                      else if (contagem_menor) prox = ST_PROXIMO;
                      else if (!ultima_rodada) prox = ST_PROX_RODADA;
                      else                     prox = ST_FIM_ACERTO;
      ST_PROXIMO,
      ST_PROX_RODADA: prox = ST_ESPERA;
      ST_FIM_ACERTO,
      ST_FIM_TIMEOUT,
      ST_FIM_ERRO:    if (iniciar) prox = ST_PREPARA;
      default:        prox = ST_INICIAL;
    endcase
  end

  always_comb begin
    zera         = (estado == ST_PREPARA);
    conta_tempo  = (estado == ST_ESPERA);
    zera_tempo   = (estado == ST_PROXIMO) || (estado == ST_PROX_RODADA);
    registra     = (estado == ST_REGISTRA);
    inc_contagem = (estado == ST_PROXIMO);
    inc_rodada   = (estado == ST_PROX_RODADA);
    acertou      = (estado == ST_FIM_ACERTO);
    timeout      = (estado == ST_FIM_TIMEOUT);
    errou        = (estado == ST_FIM_ERRO) || (estado == ST_FIM_TIMEOUT);
    pronto       = acertou || errou;
  end

  assign mem_addr    = contagem;
  assign db_estado   = estado;
  assign db_rodada   = rodada;
  assign db_contagem = contagem;
  assign db_jogada   = jogada_reg;
  assign db_igual    = igual;

endmodule

// File: doc/circuito_sequencia_rodadas.md
Name: circuito_sequencia_rodadas

Overview:
Parametrised successor of the single-pass memory checker, organised as a round-based sequence game. In round r the player must reproduce memory positions 0..r. Each jogada is one 0→nonzero edge of the switch input. An optional per-jogada timeout ends the game. Sits at top level beside an external asynchronous ROM; raw debug buses go to board hexa7seg decoders.

Parameters:
WIDTH, 4, width of chaves, the jogada register and memory data
DEPTH, 16, number of sequence positions and rounds (≥2); ADDR_W = $clog2(DEPTH)
TIMEOUT, 5000, cycles allowed in ESPERA per jogada; 0 disables timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces INICIAL
iniciar  in  1  level; starts or restarts the game
chaves  in  WIDTH  player switches
mem_addr  out  ADDR_W  ROM address, equal to the position counter
mem_data  in  WIDTH  ROM data, combinational from mem_addr
pronto  out  1  game finished
acertou  out  1  full sequence completed
errou  out  1  wrong jogada or timeout
timeout  out  1  game ended by timeout
db_estado  out  4  state code
db_rodada  out  ADDR_W  round counter
db_contagem  out  ADDR_W  position counter
db_jogada  out  WIDTH  jogada register
db_igual  out  1  jogada register == mem_data

Behaviour:
- Reset values: state INICIAL; position counter, round counter, timer, jogada register and edge-detector history all 0. Every output is 0, except mem_addr, which is 0.
- jogada = (chaves != 0) && (previous-cycle chaves == 0). The history register updates every cycle.
- State encoding for db_estado: INICIAL 0, PREPARA 1, ESPERA 3, REGISTRA 4, COMPARA 5, PROXIMO 6, PROX_RODADA 7, FIM_ACERTO A, FIM_TIMEOUT D, FIM_ERRO E.
- INICIAL: iniciar=1 → PREPARA.
- PREPARA: zero both counters, the timer and the jogada register → ESPERA.
- ESPERA: timer increments each cycle.
  - jogada=1 → REGISTRA.
  - Otherwise, if TIMEOUT>0 and timer==TIMEOUT-1 → FIM_TIMEOUT.
  - A jogada wins over timeout in the same cycle.
- REGISTRA: the jogada register loads the chaves value present in this cycle → COMPARA. Players hold chaves for ≥2 cycles.
- COMPARA: igual = (jogada register == mem_data).
  - !igual → FIM_ERRO.
  - igual and contagem<rodada → PROXIMO.
  - igual, contagem==rodada and rodada<DEPTH-1 → PROX_RODADA.
  - igual, contagem==rodada==DEPTH-1 → FIM_ACERTO.
- PROXIMO: contagem+1; timer zeroed → ESPERA.
- PROX_RODADA: rodada+1; contagem zeroed; timer zeroed → ESPERA.
- Final states (FIM_*):
  - pronto=1 in all three.
  - FIM_ACERTO: acertou=1.
  - FIM_ERRO: errou=1.
  - FIM_TIMEOUT: errou=1 and timeout=1.
  - Hold until iniciar=1 → PREPARA.
- Output decoding: all status outputs are Moore, decoded from the state register. They are valid in the first cycle the final state is held.
- Counters never wrap in normal operation. The FSM stops before contagem or rodada exceed DEPTH-1.
- Timer width is $clog2(TIMEOUT+1); it saturates and does not wrap.
- iniciar in non-final, non-INICIAL states is ignored.
- Asynchronous reset mid-game returns immediately to INICIAL with all reset values.
- Latency: a correct jogada detected in cycle t leaves the FSM back in ESPERA at t+4 (ESPERA→REGISTRA→COMPARA→PROXIMO/PROX_RODADA→ESPERA).

Decomposition:
- Shared package: state codes (4-bit localparams), and the ADDR_W and timer-width helper functions.
- One sub-module: sequencia_fluxo_dados, holding the counters, timer, jogada register, edge detector and comparator. The FSM lives in the top module.

Test Plan:
Use DEPTH=4, WIDTH=4, TIMEOUT=8, ROM = {1,2,4,8}.
- Full win: play 1 | 1,2 | 1,2,4 | 1,2,4,8, each switch pulse 2 cycles with ≥1 zero cycle between pulses → pronto=1, acertou=1, errou=0, db_estado=A, db_rodada=3.
- Wrong in round 2: play 1 | 1,2 | 1,4 → pronto=1, errou=1, timeout=0, db_estado=E, db_jogada=4, db_rodada=2, db_contagem=1.
- Timeout: iniciar, then no jogada → FIM_TIMEOUT exactly 8 cycles after entering ESPERA; errou=1, timeout=1, db_estado=D.
- Held switch: chaves held at 1 for 20 cycles → only one jogada registered; later timeout with rodada=1, contagem=0.
- Restart: in FIM_ERRO, pulse iniciar → PREPARA next cycle; all counters 0; a full win follows.
- Async reset mid-game: assert reset between clock edges in COMPARA → db_estado=0 and all outputs 0 before the next edge.
